// File: rtl/mux_8_1_rr_arbiter_if.sv
// Request/data/grant bundle shared between the requesters and the round-robin arbiter.
interface mux_8_1_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] din;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       f;
  logic [3:0] hold_cnt;

  modport master (output req, din, input sel, gnt, busy, f, hold_cnt);
  modport slave  (input req, din, output sel, gnt, busy, f, hold_cnt);
endinterface

// File: rtl/mux_8_1_rr_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 mux, with an optional tenure limit.
module mux_8_1 (
  output logic       f,
  input  logic [2:0] sel,
  input  logic [7:0] i
);
  assign f = i[sel];
endmodule

module mux_8_1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic clk,
  input logic rst_n,
  mux_8_1_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit         ROTATE   = (MAX_HOLD != 0);
  localparam logic [3:0] HOLD_SAT = ROTATE ? 4'(MAX_HOLD) : 4'd15;

  state_t     state_q, state_n;
  logic [2:0] sel_q, sel_n, ptr_q, ptr_n;
  logic [7:0] gnt_q, gnt_n;
  logic       busy_q, busy_n;
  logic [3:0] hold_q, hold_n;
  logic [7:0] others;
  logic [3:0] idle_pick, rot_pick;
  logic       mux_f;

  // Returns {found, index} of the first set bit scanning upward from p, wrapping mod 8.
  function automatic logic [3:0] scan(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = p + 3'(k);
      if (!res[3] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_n   = state_q;
    sel_n     = sel_q;
    gnt_n     = gnt_q;
    busy_n    = busy_q;
    hold_n    = hold_q;
    ptr_n     = ptr_q;
    others    = bus.req & ~(8'b1 << sel_q);
    idle_pick = scan(bus.req, ptr_q);
    rot_pick  = scan(others, sel_q + 3'd1);
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_n = GRANT;
          sel_n   = idle_pick[2:0];
          gnt_n   = 8'b1 << idle_pick[2:0];
          busy_n  = 1'b1;
          hold_n  = 4'd1;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          ptr_n = sel_q + 3'd1;
          if (|others) begin
            sel_n  = rot_pick[2:0];
            gnt_n  = 8'b1 << rot_pick[2:0];
            hold_n = 4'd1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
            hold_n  = '0;
          end
        end else if (ROTATE && hold_q == HOLD_SAT && |others) begin
          ptr_n  = sel_q + 3'd1;
          sel_n  = rot_pick[2:0];
          gnt_n  = 8'b1 << rot_pick[2:0];
          hold_n = 4'd1;
        end else if (hold_q != HOLD_SAT) begin
          hold_n = hold_q + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      gnt_q   <= gnt_n;
      busy_q  <= busy_n;
      hold_q  <= hold_n;
      ptr_q   <= ptr_n;
    end
  end

  mux_8_1 u_mux (.f(mux_f), .sel(sel_q), .i(bus.din));

  assign bus.sel      = sel_q;
  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.hold_cnt = hold_q;
  assign bus.f        = mux_f & busy_q;
endmodule

// File: tb/tb_mux_8_1_rr_arbiter.sv
// Directed scoreboard bench for the round-robin arbiter, MAX_HOLD=4 and MAX_HOLD=0 instances.
module tb_mux_8_1_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req4 = '0, din4 = '0, req0 = '0, din0 = '0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    bit         dut;   // 0: MAX_HOLD=4 instance, 1: MAX_HOLD=0 instance
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic [3:0] hold;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  mux_8_1_rr_arbiter_if b4 ();
  mux_8_1_rr_arbiter_if b0 ();
  assign b4.req = req4;
  assign b4.din = din4;
  assign b0.req = req0;
  assign b0.din = din0;

  mux_8_1_rr_arbiter #(.MAX_HOLD(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  mux_8_1_rr_arbiter #(.MAX_HOLD(0)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit d, input logic [7:0] g, input logic [2:0] s,
                      input logic b, input logic [3:0] h);
    exp_t e;
    e.dut = d; e.gnt = g; e.sel = s; e.busy = b; e.hold = h;
    q.push_back(e);
  endtask

  task automatic compare_all(input string tag);
    exp_t       e;
    logic [7:0] og, dn;
    logic [2:0] os;
    logic       ob, of;
    logic [3:0] oh;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.dut) begin
        og = b0.gnt; os = b0.sel; ob = b0.busy; of = b0.f; oh = b0.hold_cnt; dn = din0;
      end else begin
        og = b4.gnt; os = b4.sel; ob = b4.busy; of = b4.f; oh = b4.hold_cnt; dn = din4;
      end
      chk({tag, " gnt"},  32'(og), 32'(e.gnt));
      chk({tag, " sel"},  32'(os), 32'(e.sel));
      chk({tag, " busy"}, 32'(ob), 32'(e.busy));
      chk({tag, " hold"}, 32'(oh), 32'(e.hold));
      chk({tag, " f"},    32'(of), 32'(e.busy & dn[e.sel]));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int ow[5];
    ow = '{0, 4, 6, 0, 4};

    // Reset state and idle
    #1;
    push(0, '0, 0, 0, 0); push(1, '0, 0, 0, 0);
    compare_all("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(0, '0, 0, 0, 0); push(1, '0, 0, 0, 0);
      step($sformatf("idle%0d", i));
    end

    // Single requester, combinational f, release
    req4 = 8'h01; din4 = 8'h01;
    push(0, 8'h01, 0, 1, 1); step("single_gnt");
    din4 = 8'h00; #1;
    push(0, 8'h01, 0, 1, 1); compare_all("single_f0");
    req4 = 8'h00;
    push(0, '0, 0, 0, 0); step("single_rel");

    // Round-robin with forced rotation every 4 cycles
    pulse_reset();
    req4 = 8'h51; din4 = 8'h51;
    foreach (ow[k]) begin
      for (int h = 1; h <= 4; h++) begin
        push(0, 8'(1 << ow[k]), 3'(ow[k]), 1, 4'(h));
        step($sformatf("rr_o%0d_h%0d", ow[k], h));
      end
    end
    push(0, 8'h40, 6, 1, 1); step("rr_to6");

    // Release by 6 with wrap-around to 7, then 7 releases to 1
    req4 = 8'h82;
    push(0, 8'h80, 7, 1, 1); step("wrap_7");
    req4 = 8'h02;
    push(0, 8'h02, 1, 1, 1); step("wrap_1");
    req4 = 8'h00;
    push(0, '0, 1, 0, 0); step("wrap_idle");

    // Lone requester keeps its grant; hold_cnt saturates at MAX_HOLD
    req4 = 8'h01;
    for (int h = 1; h <= 6; h++) begin
      push(0, 8'h01, 0, 1, 4'(h > 4 ? 4 : h));
      step($sformatf("sat4_%0d", h));
    end
    req4 = 8'h00;
    push(0, '0, 0, 0, 0); step("sat4_idle");

    // Unlimited tenure: hold_cnt saturates at 15, release hands over without a bubble
    req0 = 8'h41; din0 = 8'h41;
    for (int h = 1; h <= 17; h++) begin
      push(1, 8'h01, 0, 1, 4'(h > 15 ? 15 : h));
      step($sformatf("unl_%0d", h));
    end
    req0 = 8'h40;
    push(1, 8'h40, 6, 1, 1); step("unl_to6");
    push(1, 8'h40, 6, 1, 2); step("unl_6h2");

    // Asynchronous reset mid-grant, then arbitration restarts from pointer 0
    #3 rst_n = 1'b0;
    #1;
    push(1, '0, 0, 0, 0);
    compare_all("async_rst");
    req0 = 8'h41;
    #1 rst_n = 1'b1;
    push(1, 8'h01, 0, 1, 1); step("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_8_1_rr_arbiter.md
Name: mux_8_1_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 mux output between 8 requesters.
- Each requester presents one data bit and one request line.
- The block decides which requester owns the shared line, drives the 3-bit select of an internal mux_8_1 instance (ports f, sel, i), and gates the shared output.
- A tenure limit stops one requester from holding the line forever.

Parameters:
- MAX_HOLD, default 4: max consecutive grant cycles while another requester waits. 0 = unlimited tenure. Legal range 0..15.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request lines, bit k = requester k; level-sensitive
- din  input  8  data bits, bit k from requester k; drives mux_8_1 .i
- sel  output  3  registered select, drives mux_8_1 .sel
- gnt  output  8  registered one-hot grant; all-zero when idle
- busy  output  1  registered; 1 while any grant is active
- f  output  1  shared output = mux_8_1 .f AND busy (0 when idle)
- hold_cnt  output  4  registered cycles served in the current tenure

Behaviour:
Reset:
- rst_n low asynchronously clears sel=0, gnt=0, busy=0, hold_cnt=0, internal priority pointer ptr=0, state=IDLE.
- f is 0 as a consequence of busy=0.
- Asserting reset mid-grant drops the grant immediately, with no clock edge needed.

Priority scan:
- Search order from pointer p is p, p+1, ..., p+7, all mod 8.
- The winner is the first index in that order whose req bit is 1.
- In IDLE, p = ptr.
- When rotating away from current owner s, p = s+1 mod 8 and s is excluded.
- Wrap-around required, e.g. s=7 scans 0,1,...,6.

State machine, two states:
- IDLE (busy=0, gnt=0):
  - If req != 0, at the next edge: winner w is granted, sel=w, gnt=1<<w, busy=1, hold_cnt=1, state=GRANT.
  - Latency is 1 cycle from req sampled high to gnt/sel valid.
  - If req == 0, stay in IDLE; sel keeps its last value.
- GRANT, owner s=sel, evaluated each edge:
  - Release (req[s]==0): ptr=s+1 mod 8. If another request is pending, switch directly to the scan winner (gnt/sel update, hold_cnt=1), with no idle bubble. Otherwise go to IDLE with gnt=0, busy=0, hold_cnt=0; sel holds s.
  - Forced rotation (MAX_HOLD!=0, hold_cnt==MAX_HOLD, req[s]==1, and another req pending): switch to the scan winner from s+1, hold_cnt=1, ptr=s+1.
  - Otherwise keep the grant. hold_cnt increments and saturates at MAX_HOLD (saturates at 15 when MAX_HOLD=0). With no competitor, tenure continues indefinitely.
- A requester that loses its grant by rotation and still requests is re-queued at its normal position. It cannot win again before all other pending requesters have been served once.
- Simultaneous release and arrival of new requests in the same cycle: new requests take part in that cycle's scan.

Invariants:
- gnt is always zero or one-hot.
- When busy=1, gnt == 1<<sel.
- hold_cnt is never 0 while busy=1.
- f is never X after reset.

Test Plan:
- Reset/idle: rst_n=0 then 1, req=0 for 10 cycles -> sel=0, gnt=0, busy=0, f=0 throughout.
- Single requester: req=8'b0000_0001, din=8'b0000_0001 -> one edge later gnt=0x01, sel=0, f=1. Set din=0 -> f=0 combinationally. Drop req -> next edge gnt=0, busy=0.
- Round-robin fairness: MAX_HOLD=4, req=8'b0101_0001 held constant -> grant sequence 0,4,6,0,... with 4 cycles each. No bubbles at switches. hold_cnt counts 1..4.
- Wrap-around and release: owner sel=6 drops its req while req=8'b1000_0010 -> next edge sel=7 (not 1). Later 7 drops -> sel=1.
- Unlimited tenure: MAX_HOLD=0, req=8'b0100_0001 -> requester 0 holds until its req drops. hold_cnt saturates at 15. Then sel=6 with no idle cycle.
- Mid-grant reset: while gnt=0x40 and din[6]=1, pulse rst_n low between clock edges -> gnt=0, busy=0, f=0 immediately. After release, re-arbitration starts from ptr=0.
